// File: rtl/clock_pkg.sv
// Shared mode encodings and counter widths for the clock set controller.
package clock_pkg;

  localparam int DB_W = 16;
  localparam int TM_W = 24;
  localparam int TO_W = 8;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN     = 2'b00;
  localparam mode_t MODE_SET_HR  = 2'b01;
  localparam mode_t MODE_SET_MIN = 2'b10;

  function automatic logic is_set_mode(input mode_t m);
    return (m == MODE_SET_HR) || (m == MODE_SET_MIN);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and one-cycle rising-edge pulse
// for one raw pushbutton.
module btn_debounce
  import clock_pkg::*;
#(
  parameter logic [DB_W-1:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam logic [DB_W-1:0] DB_LAST = DEBOUNCE_CYC - DB_W'(1);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;
  logic            r_press;

  // Any bounce back to the committed level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// RUN/SET_HR/SET_MIN sequencer: button debounce, hold-to-repeat, digit blink.
// Optional idle exit from set states when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [DB_W-1:0] DEBOUNCE_CYC  = 16'd50000,
  parameter logic [TM_W-1:0] REPEAT_DELAY  = 24'd12500000,
  parameter logic [TM_W-1:0] REPEAT_PERIOD = 24'd2500000,
  parameter logic [TM_W-1:0] BLINK_HALF    = 24'd6250000,
  parameter logic [TO_W-1:0] TIMEOUT_S     = 8'd30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode_raw,
  input  logic       btn_up_raw,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam logic [TM_W-1:0] REP_FIRST  = REPEAT_DELAY - TM_W'(1);
  localparam logic [TM_W-1:0] REP_NEXT   = REPEAT_PERIOD - TM_W'(1);
  localparam logic [TM_W-1:0] BLINK_LAST = BLINK_HALF - TM_W'(1);

  logic w_unused_mode_level, w_mode_press, w_up_level, w_up_press;
  logic w_in_set, w_rep_fire, w_up_evt, w_timeout, w_activity;
  mode_t w_state_next;

  mode_t           r_state;
  logic            r_sec_inc, r_min_inc, r_hr_inc, r_sec_clr;
  logic [TM_W-1:0] r_rep_cnt, r_blink_cnt;
  logic            r_rep_armed, r_rep_first, r_phase;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .i_raw(btn_mode_raw),
    .o_level(w_unused_mode_level), .o_press(w_mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(clk), .rst_n(rst_n), .i_raw(btn_up_raw),
    .o_level(w_up_level), .o_press(w_up_press)
  );

  assign w_in_set   = is_set_mode(r_state);
  assign w_rep_fire = w_in_set & r_rep_armed & w_up_level &
                      (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));
  // MODE always wins over a coincident UP press or repeat.
  assign w_up_evt   = w_in_set & (w_up_press | w_rep_fire) & ~w_mode_press;
  assign w_activity = w_mode_press | w_up_press | w_rep_fire;

`ifdef CLOCK_SET_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = w_in_set & tick_1hz & ~w_activity &
                     (r_to_cnt == TIMEOUT_S - TO_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_in_set || w_activity || (w_state_next != r_state)) begin
      r_to_cnt <= '0;
    end else if (tick_1hz) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_S;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MODE_RUN:     if (w_mode_press) w_state_next = MODE_SET_HR;
      MODE_SET_HR:  if (w_mode_press) w_state_next = MODE_SET_MIN;
                    else if (w_timeout) w_state_next = MODE_RUN;
      MODE_SET_MIN: if (w_mode_press || w_timeout) w_state_next = MODE_RUN;
      default:      w_state_next = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MODE_RUN;
      r_sec_inc <= 1'b0;
      r_min_inc <= 1'b0;
      r_hr_inc  <= 1'b0;
      r_sec_clr <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sec_inc <= (r_state == MODE_RUN) & tick_1hz;
      r_hr_inc  <= w_up_evt & (r_state == MODE_SET_HR);
      r_min_inc <= w_up_evt & (r_state == MODE_SET_MIN);
      r_sec_clr <= w_in_set & (w_state_next == MODE_RUN);
    end
  end

  // Repeats need a fresh UP press in the current set state to arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_first <= 1'b0;
    end else if (!w_in_set || w_mode_press || !w_up_level) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_first <= 1'b0;
    end else if (w_up_press) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (r_rep_armed) begin
      r_rep_cnt <= r_rep_cnt + TM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if ((w_state_next != r_state) || w_up_evt) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + TM_W'(1);
    end
  end

  assign sec_inc   = r_sec_inc;
  assign min_inc   = r_min_inc;
  assign hr_inc    = r_hr_inc;
  assign sec_clr   = r_sec_clr;
  assign mode      = r_state;
  assign blank_hr  = (r_state == MODE_SET_HR) & r_phase & ~w_up_level;
  assign blank_min = (r_state == MODE_SET_MIN) & r_phase & ~w_up_level;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/blink periods;
// the timeout step follows CLOCK_SET_TIMEOUT_EN.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode_raw = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       sec_inc, min_inc, hr_inc, sec_clr;
  logic [1:0] mode;
  logic       blank_hr, blank_min;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_sec = 0, n_min = 0, n_hr = 0, n_clr = 0;
  int excl_bad = 0, clr_bad = 0, blank_bad = 0;
  int min_t [0:31];

  int   h0, s0, m0, c0, base, errs;
  logic prev;

  `define CHK(TAG, OBS, EXP) \
    begin \
      checks++; \
      assert ((OBS) === (EXP)) else begin \
        failures++; \
        $error("FAIL %s observed=%0d expected=%0d", TAG, (OBS), (EXP)); \
      end \
    end

  clock_set_ctrl #(
    .DEBOUNCE_CYC (16'd4),
    .REPEAT_DELAY (24'd20),
    .REPEAT_PERIOD(24'd5),
    .BLINK_HALF   (24'd8),
    .TIMEOUT_S    (8'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode_raw(btn_mode_raw), .btn_up_raw(btn_up_raw),
    .sec_inc(sec_inc), .min_inc(min_inc), .hr_inc(hr_inc), .sec_clr(sec_clr),
    .mode(mode), .blank_hr(blank_hr), .blank_min(blank_min)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sec_inc) n_sec++;
    if (hr_inc) n_hr++;
    if (min_inc) begin
      if (n_min < 32) min_t[n_min] = cyc;
      n_min++;
    end
    if (sec_clr) begin
      n_clr++;
      if (mode !== 2'b00) clr_bad++;
    end
    if ((32'(sec_inc) + 32'(min_inc) + 32'(hr_inc)) > 1) excl_bad++;
    if ((blank_hr && mode !== 2'b01) || (blank_min && mode !== 2'b10)) blank_bad++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode_raw = 1'b1;
    wait_cyc(8);
    btn_mode_raw = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    // Reset
    wait_cyc(3);
    `CHK("reset_outputs", {sec_inc, min_inc, hr_inc, sec_clr, mode, blank_hr, blank_min}, 8'd0)
    rst_n = 1'b1;
    wait_cyc(2);
    $display("step reset: mode=%0d", mode);

    // RUN: sec_inc follows tick by one cycle, UP ignored
    btn_up_raw = 1'b1;
    errs = 0;
    prev = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      wait_cyc(1);
      if (sec_inc !== prev) errs++;
      prev = ((i % 10) == 0) && (i < 50);
      tick_1hz = prev;
    end
    tick_1hz = 1'b0;
    btn_up_raw = 1'b0;
    wait_cyc(10);
    `CHK("run_sec_align", errs, 0)
    `CHK("run_sec_count", n_sec, 5)
    `CHK("run_up_ignored", n_hr + n_min, 0)
    $display("step run: sec_inc=%0d hr+min=%0d", n_sec, n_hr + n_min);

    // MODE -> SET_HR, blink phase every 8 cycles
    btn_mode_raw = 1'b1;
    wait_cyc(8);
    `CHK("mode_set_hr", mode, 2'b01)
    `CHK("blink_e8", blank_hr, 1'b0)
    btn_mode_raw = 1'b0;
    wait_cyc(6);
    `CHK("blink_e14", blank_hr, 1'b0)
    wait_cyc(1);
    `CHK("blink_e15", blank_hr, 1'b1)
    wait_cyc(7);
    `CHK("blink_e22", blank_hr, 1'b1)
    wait_cyc(1);
    `CHK("blink_e23", blank_hr, 1'b0)
    wait_cyc(5);
    $display("step set_hr entry: mode=%0d", mode);

    // SET_HR: 3-cycle glitch, then 8-cycle hold with ticks
    btn_up_raw = 1'b1;
    wait_cyc(3);
    btn_up_raw = 1'b0;
    wait_cyc(10);
    `CHK("glitch_no_hr", n_hr, 0)
    h0 = n_hr;
    s0 = n_sec;
    btn_up_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(1);
      tick_1hz = (i == 2) || (i == 5);
    end
    tick_1hz = 1'b0;
    btn_up_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wait_cyc(1);
      tick_1hz = (i == 4);
    end
    tick_1hz = 1'b0;
    `CHK("hold8_one_hr", n_hr - h0, 1)
    `CHK("set_no_sec", n_sec - s0, 0)
    $display("step hold8: hr_inc=%0d sec_inc=%0d", n_hr - h0, n_sec - s0);

    // SET_MIN: 40-cycle hold -> strobe then +20,+25,+30,+35
    press_mode();
    `CHK("mode_set_min", mode, 2'b10)
    `CHK("no_clr_yet", n_clr, 0)
    m0 = n_min;
    base = cyc;
    btn_up_raw = 1'b1;
    wait_cyc(40);
    btn_up_raw = 1'b0;
    wait_cyc(40);
    `CHK("rep_count", n_min - m0, 5)
    `CHK("rep_first_lat", min_t[m0] - base, 7)
    `CHK("rep_delay", min_t[m0 + 1] - min_t[m0], 20)
    `CHK("rep_p1", min_t[m0 + 2] - min_t[m0], 25)
    `CHK("rep_p2", min_t[m0 + 3] - min_t[m0], 30)
    `CHK("rep_p3", min_t[m0 + 4] - min_t[m0], 35)
    $display("step repeat: min_inc=%0d", n_min - m0);

    // SET_MIN -> RUN with sec_clr
    press_mode();
    `CHK("mode_run", mode, 2'b00)
    `CHK("clr_once", n_clr, 1)
    $display("step exit: mode=%0d sec_clr=%0d", mode, n_clr);

    // MODE and UP together in SET_HR
    press_mode();
    `CHK("mode_set_hr2", mode, 2'b01)
    h0 = n_hr;
    m0 = n_min;
    btn_mode_raw = 1'b1;
    btn_up_raw = 1'b1;
    wait_cyc(30);
    btn_mode_raw = 1'b0;
    btn_up_raw = 1'b0;
    wait_cyc(10);
    `CHK("simul_mode", mode, 2'b10)
    `CHK("simul_no_hr", n_hr - h0, 0)
    `CHK("simul_no_min", n_min - m0, 0)
    press_mode();
    `CHK("clr_twice", n_clr, 2)
    $display("step simultaneous: mode=%0d", mode);

    // Async reset mid-repeat
    press_mode();
    h0 = n_hr;
    btn_up_raw = 1'b1;
    wait_cyc(30);
    `CHK("pre_reset_hr", n_hr - h0, 2)
    rst_n = 1'b0;
    #1;
    `CHK("async_reset", {sec_inc, min_inc, hr_inc, sec_clr, mode, blank_hr, blank_min}, 8'd0)
    wait_cyc(2);
    rst_n = 1'b1;
    btn_up_raw = 1'b0;
    wait_cyc(15);
    `CHK("post_reset_mode", mode, 2'b00)
    `CHK("post_reset_no_hr", n_hr - h0, 2)
    $display("step reset mid-repeat: mode=%0d", mode);

    // Idle ticks in SET_HR
    press_mode();
    c0 = n_clr;
    for (int k = 0; k < 3; k++) begin
      tick_1hz = 1'b1;
      wait_cyc(1);
      tick_1hz = 1'b0;
      wait_cyc(9);
    end
`ifdef CLOCK_SET_TIMEOUT_EN
    `CHK("timeout_mode", mode, 2'b00)
    `CHK("timeout_clr", n_clr - c0, 1)
`else
    `CHK("no_timeout_mode", mode, 2'b01)
    `CHK("no_timeout_clr", n_clr - c0, 0)
`endif
    $display("step idle ticks: mode=%0d", mode);

    `CHK("strobe_exclusive", excl_bad, 0)
    `CHK("clr_with_run", clr_bad, 0)
    `CHK("blank_in_state", blank_bad, 0)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
